// File: rtl/rename_register_file.sv
// Architectural register file with per-register busy bit and ROB tag for renaming.
// Combinational read ports forward a same-cycle commit; flush clears every pending rename.
module rename_register_file #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int TAG_WIDTH = 4,
    parameter int NUM_READ  = 2,
    parameter int RIDX      = $clog2(NUM_REGS)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic [NUM_READ*RIDX-1:0]  read_id,
    output logic [NUM_READ*XLEN-1:0]  read_data,
    output logic [NUM_READ-1:0]       read_busy,
    output logic [NUM_READ*TAG_WIDTH-1:0] read_tag,
    input  logic                      rename_signal,
    input  logic [RIDX-1:0]           rename_id,
    input  logic [TAG_WIDTH-1:0]      rename_tag,
    input  logic                      commit_signal,
    input  logic [RIDX-1:0]           commit_id,
    input  logic [TAG_WIDTH-1:0]      commit_tag,
    input  logic [XLEN-1:0]           commit_data,
    input  logic                      flush_signal
);

    logic [XLEN-1:0]      reg_value [NUM_REGS];
    logic                 reg_busy  [NUM_REGS];
    logic [TAG_WIDTH-1:0] reg_tag   [NUM_REGS];

    // x0 is hardwired to zero and out-of-range indices behave like it
    function automatic logic valid_index(input logic [RIDX-1:0] id);
        return (id != '0) && (int'(id) < NUM_REGS);
    endfunction

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_value[i] <= '0;
                reg_busy[i]  <= 1'b0;
                reg_tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (flush_signal) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    reg_busy[i] <= 1'b0;
                    reg_tag[i]  <= '0;
                end
            end
            // Only the rename that produced this tag may be cleared; a younger rename keeps ownership
            if (commit_signal && valid_index(commit_id)) begin
                reg_value[commit_id] <= commit_data;
                if (reg_busy[commit_id] && (reg_tag[commit_id] == commit_tag)) begin
                    reg_busy[commit_id] <= 1'b0;
                    reg_tag[commit_id]  <= '0;
                end
            end
            if (rename_signal && !flush_signal && valid_index(rename_id)) begin
                reg_busy[rename_id] <= 1'b1;
                reg_tag[rename_id]  <= rename_tag;
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [RIDX-1:0]      id;
        logic [XLEN-1:0]      data;
        logic                 busy;
        logic [TAG_WIDTH-1:0] tag;

        assign id = read_id[k*RIDX +: RIDX];

        always_comb begin
            data = '0;
            busy = 1'b0;
            tag  = '0;
            if (valid_index(id)) begin
                data = reg_value[id];
                busy = reg_busy[id];
                tag  = reg_tag[id];
                if (rdy_in && commit_signal && (commit_id == id)) begin
                    data = commit_data;
                    if (busy && (tag == commit_tag)) begin
                        busy = 1'b0;
                        tag  = '0;
                    end
                end
            end
        end

        assign read_data[k*XLEN +: XLEN]           = data;
        assign read_busy[k]                        = busy;
        assign read_tag[k*TAG_WIDTH +: TAG_WIDTH]  = tag;
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed scenarios then random traffic
// compared against an array-based model of the register/busy/tag rules.
module tb_rename_register_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int TW   = 4;
    localparam int NRD  = 2;
    localparam int RIDX = 5;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b0;
    logic                 rdy_in = 1'b0;
    logic [NRD*RIDX-1:0]  read_id = '0;
    logic [NRD*XLEN-1:0]  read_data;
    logic [NRD-1:0]       read_busy;
    logic [NRD*TW-1:0]    read_tag;
    logic                 rename_signal = 1'b0;
    logic [RIDX-1:0]      rename_id = '0;
    logic [TW-1:0]        rename_tag = '0;
    logic                 commit_signal = 1'b0;
    logic [RIDX-1:0]      commit_id = '0;
    logic [TW-1:0]        commit_tag = '0;
    logic [XLEN-1:0]      commit_data = '0;
    logic                 flush_signal = 1'b0;

    int testCount = 0;
    int failCount = 0;

    logic [XLEN-1:0] modelVal  [NREG];
    logic            modelBusy [NREG];
    logic [TW-1:0]   modelTag  [NREG];

    rename_register_file #(
        .XLEN(XLEN), .NUM_REGS(NREG), .TAG_WIDTH(TW), .NUM_READ(NRD)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .read_id(read_id), .read_data(read_data), .read_busy(read_busy), .read_tag(read_tag),
        .rename_signal(rename_signal), .rename_id(rename_id), .rename_tag(rename_tag),
        .commit_signal(commit_signal), .commit_id(commit_id), .commit_tag(commit_tag),
        .commit_data(commit_data), .flush_signal(flush_signal)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) begin
            modelVal[i]  = '0;
            modelBusy[i] = 1'b0;
            modelTag[i]  = '0;
        end
    endtask

    // Expected read of one port: stored state, with a same-cycle commit forwarded when ready
    task automatic modelRead(input int id, output logic [XLEN-1:0] d, output logic b, output logic [TW-1:0] t);
        d = '0; b = 1'b0; t = '0;
        if (id != 0) begin
            d = modelVal[id]; b = modelBusy[id]; t = modelTag[id];
            if (rdy_in && commit_signal && int'(commit_id) == id) begin
                d = commit_data;
                if (modelBusy[id] && modelTag[id] == commit_tag) begin
                    b = 1'b0; t = '0;
                end
            end
        end
    endtask

    task automatic modelUpdate();
        int cid, rid;
        cid = int'(commit_id);
        rid = int'(rename_id);
        if (!rst_in || !rdy_in) return;
        if (commit_signal && cid != 0) begin
            modelVal[cid] = commit_data;
            if (modelBusy[cid] && modelTag[cid] == commit_tag) begin
                modelBusy[cid] = 1'b0;
                modelTag[cid]  = '0;
            end
        end
        if (flush_signal) begin
            for (int i = 0; i < NREG; i++) begin
                modelBusy[i] = 1'b0;
                modelTag[i]  = '0;
            end
        end else if (rename_signal && rid != 0) begin
            modelBusy[rid] = 1'b1;
            modelTag[rid]  = rename_tag;
        end
    endtask

    task automatic checkPorts();
        logic [XLEN-1:0] d;
        logic            b;
        logic [TW-1:0]   t;
        int              id;
        for (int k = 0; k < NRD; k++) begin
            id = int'(read_id[k*RIDX +: RIDX]);
            modelRead(id, d, b, t);
            checkOutput($sformatf("port%0d data x%0d", k, id), 64'(read_data[k*XLEN +: XLEN]), 64'(d));
            checkOutput($sformatf("port%0d busy x%0d", k, id), 64'(read_busy[k]), 64'(b));
            checkOutput($sformatf("port%0d tag x%0d", k, id), 64'(read_tag[k*TW +: TW]), 64'(t));
        end
    endtask

    task automatic applyStimulus(input logic rdy, input int r0, input int r1,
                                 input logic ren, input int renId, input int renTag,
                                 input logic com, input int comId, input int comTag,
                                 input logic [XLEN-1:0] comData, input logic flush);
        rdy_in        = rdy;
        read_id       = {RIDX'(r1), RIDX'(r0)};
        rename_signal = ren;
        rename_id     = RIDX'(renId);
        rename_tag    = TW'(renTag);
        commit_signal = com;
        commit_id     = RIDX'(comId);
        commit_tag    = TW'(comTag);
        commit_data   = comData;
        flush_signal  = flush;
        #1;
    endtask

    task automatic idle(input int r0, input int r1);
        applyStimulus(1'b1, r0, r1, 1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b0);
    endtask

    // Called one time unit after a negedge: check reads, clock once, advance the model
    task automatic runCycle();
        checkPorts();
        @(posedge clk_in);
        modelUpdate();
        @(negedge clk_in);
    endtask

    initial begin
        modelReset();
        @(negedge clk_in);
        idle(5, 31);
        runCycle();
        rst_in = 1'b1;

        applyStimulus(1'b1, 0, 0, 1'b1, 0, 3, 1'b0, 0, 0, '0, 1'b0);
        runCycle();
        idle(0, 0);
        checkOutput("x0 busy after rename", 64'(read_busy[0]), 64'd0);
        runCycle();

        applyStimulus(1'b1, 5, 5, 1'b1, 5, 7, 1'b0, 0, 0, '0, 1'b0);
        runCycle();
        idle(5, 5);
        checkOutput("x5 busy renamed", 64'(read_busy[0]), 64'd1);
        checkOutput("x5 tag renamed", 64'(read_tag[3:0]), 64'd7);
        runCycle();

        applyStimulus(1'b1, 5, 6, 1'b0, 0, 0, 1'b1, 5, 7, 32'hDEADBEEF, 1'b0);
        checkOutput("x5 bypass data", 64'(read_data[31:0]), 64'hDEADBEEF);
        checkOutput("x5 bypass busy", 64'(read_busy[0]), 64'd0);
        runCycle();
        idle(5, 5);
        checkOutput("x5 stored data", 64'(read_data[31:0]), 64'hDEADBEEF);
        checkOutput("x5 stored busy", 64'(read_busy[0]), 64'd0);
        runCycle();

        applyStimulus(1'b1, 5, 5, 1'b1, 5, 2, 1'b0, 0, 0, '0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 5, 5, 1'b1, 5, 9, 1'b0, 0, 0, '0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 5, 5, 1'b0, 0, 0, 1'b1, 5, 2, 32'h11, 1'b0);
        runCycle();
        idle(5, 5);
        checkOutput("x5 stale commit data", 64'(read_data[31:0]), 64'h11);
        checkOutput("x5 stale commit busy", 64'(read_busy[0]), 64'd1);
        checkOutput("x5 stale commit tag", 64'(read_tag[3:0]), 64'd9);
        runCycle();
        applyStimulus(1'b1, 5, 5, 1'b0, 0, 0, 1'b1, 5, 9, 32'h22, 1'b0);
        runCycle();
        idle(5, 5);
        checkOutput("x5 final busy", 64'(read_busy[0]), 64'd0);
        checkOutput("x5 final data", 64'(read_data[31:0]), 64'h22);
        runCycle();

        applyStimulus(1'b1, 8, 8, 1'b1, 8, 4, 1'b0, 0, 0, '0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 8, 8, 1'b1, 8, 4, 1'b1, 8, 4, 32'h55, 1'b0);
        runCycle();
        idle(8, 8);
        checkOutput("x8 data", 64'(read_data[31:0]), 64'h55);
        checkOutput("x8 busy rename wins", 64'(read_busy[0]), 64'd1);
        checkOutput("x8 tag", 64'(read_tag[3:0]), 64'd4);
        runCycle();

        for (int r = 1; r <= 3; r++) begin
            applyStimulus(1'b1, r, 0, 1'b1, r, r, 1'b0, 0, 0, '0, 1'b0);
            runCycle();
        end
        applyStimulus(1'b1, 2, 4, 1'b1, 4, 5, 1'b1, 2, 2, 32'h99, 1'b1);
        runCycle();
        idle(1, 2);
        checkOutput("x1 busy after flush", 64'(read_busy[0]), 64'd0);
        checkOutput("x2 data after flush", 64'(read_data[63:32]), 64'h99);
        runCycle();
        idle(3, 4);
        checkOutput("x4 busy after flush", 64'(read_busy[1]), 64'd0);
        runCycle();

        applyStimulus(1'b0, 6, 7, 1'b1, 6, 1, 1'b1, 7, 0, 32'h1, 1'b0);
        checkOutput("x7 no bypass when not ready", 64'(read_data[63:32]), 64'd0);
        runCycle();
        idle(6, 7);
        checkOutput("x6 held busy", 64'(read_busy[0]), 64'd0);
        checkOutput("x7 held data", 64'(read_data[63:32]), 64'd0);
        runCycle();

        applyStimulus(1'b1, 5, 8, 1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b0);
        #2;
        rst_in = 1'b0;
        modelReset();
        #1;
        checkOutput("async reset x8 data", 64'(read_data[63:32]), 64'd0);
        checkOutput("async reset x8 busy", 64'(read_busy[1]), 64'd0);
        checkPorts();
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int n = 0; n < 400; n++) begin
            int cid;
            int ctag;
            cid  = int'($urandom_range(0, NREG - 1));
            ctag = ($urandom_range(0, 1) == 1) ? int'(modelTag[cid]) : int'($urandom_range(0, 15));
            applyStimulus(($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 2) == 0) ? cid : int'($urandom_range(0, NREG - 1)),
                          int'($urandom_range(0, NREG - 1)),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, NREG - 1)),
                          int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), cid, ctag, $urandom(),
                          ($urandom_range(0, 19) == 0));
            runCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/rename_register_file.md
Name: rename_register_file

Overview:
- Architectural integer register file for the out-of-order RISC-V core.
- Each register carries a busy bit and a reorder-buffer tag, so dispatch can rename destinations and the commit stage can retire values.
- Provides NUM_READ combinational source-operand ports with commit bypass, plus a global flush on branch mispredict.
- Sits between the decoder/dispatch unit and the reorder buffer.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of registers; index width RIDX = clog2(NUM_REGS).
- TAG_WIDTH, 4, reorder-buffer tag width.
- NUM_READ, 2, number of independent read ports.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  ready; when low, no state changes.
- read_id  input  NUM_READ*RIDX  packed read indices, port k at bits [k*RIDX +: RIDX].
- read_data  output  NUM_READ*XLEN  per-port register value.
- read_busy  output  NUM_READ  per-port busy flag (value pending in ROB).
- read_tag  output  NUM_READ*TAG_WIDTH  per-port pending ROB tag.
- rename_signal  input  1  dispatch renames a destination this cycle.
- rename_id  input  RIDX  destination register.
- rename_tag  input  TAG_WIDTH  ROB tag assigned.
- commit_signal  input  1  ROB commits a value this cycle.
- commit_id  input  RIDX  committed register.
- commit_tag  input  TAG_WIDTH  ROB tag of committing entry.
- commit_data  input  XLEN  committed value.
- flush_signal  input  1  mispredict flush.

Behaviour:
- Reset (rst_in=0, asynchronous): all values = 0, all busy = 0, all tags = 0. read_* outputs then reflect index-addressed zero state: data 0, busy 0, tag 0. Reset mid-operation discards every pending rename.
- Reads are combinational, 0-cycle latency, and independent per port. Each port sees state before this cycle's rename and commit updates, except for the commit bypass below.
- Commit bypass: if commit_signal=1 and read_id==commit_id:
  - read_data = commit_data.
  - If the register is busy and its stored tag == commit_tag: read_busy = 0 and read_tag = 0.
  - Otherwise busy/tag are reported as stored.
  - Bypass applies even when rdy_in=0? No: with rdy_in=0, bypass is disabled and outputs show stored state.
- Register 0: always reads data 0, busy 0, tag 0. Rename and commit to index 0 are ignored. Indices >= NUM_REGS read as 0 and ignore writes.
- All updates happen on the clk_in rising edge, only when rdy_in=1.
- Commit: value[commit_id] <= commit_data unconditionally. Busy is cleared only if busy[commit_id]=1 and tag[commit_id]==commit_tag; otherwise busy and tag are unchanged, because a younger rename owns the register.
- Rename (only when flush_signal=0): busy[rename_id] <= 1, tag[rename_id] <= rename_tag.
- Rename and commit to the same register in the same cycle: the value is written, and rename wins, so busy=1 and tag=rename_tag.
- Flush: all busy <= 0 and all tags <= 0 in one cycle. rename_signal is ignored that cycle. A simultaneous commit still writes its value.
- rdy_in=0: all update inputs are ignored and state is held.

Test Plan:
- Reset then read ports 0/1 at x5/x31 -> data 0, busy 0, tag 0. Rename x0 with tag 3 -> x0 still reads busy 0.
- Rename x5 tag 7, next cycle read x5 -> busy 1, tag 7. Commit x5 tag 7 data 0xDEADBEEF -> same-cycle read shows data 0xDEADBEEF and busy 0; the following cycle shows the same values from stored state.
- Rename x5 tag 2, then rename x5 tag 9, then commit x5 tag 2 data 0x11 -> data 0x11, busy 1, tag 9 persists. Commit tag 9 data 0x22 -> busy 0, data 0x22.
- Same cycle: rename x8 tag 4 and commit x8 tag 4 data 0x55 (x8 busy with tag 4) -> next cycle data 0x55, busy 1, tag 4.
- Rename x1/x2/x3 with tags 1/2/3, then flush with simultaneous rename x4 tag 5 and commit x2 tag 2 data 0x99 -> all busy 0, x4 not busy, x2 data 0x99.
- Hold rdy_in=0 while asserting rename x6 tag 1 and commit x7 data 0x1 -> no state change. Assert rst_in low asynchronously between edges -> outputs drop to 0 immediately.
